// File: rtl/cacheline_adapter.sv
// Memory-side responder: turns one 256-bit line read/write from the arbiter into
// a 4-beat 64-bit burst on the physical memory port, then pulses pmem_resp once.
module cacheline_adapter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 256,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BEAT_WIDTH-1:0] mem_wdata,
  input  logic [BEAT_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam int BEATS = LINE_WIDTH / BEAT_WIDTH;
  localparam int CNT_W = $clog2(BEATS);
  localparam int OFF_W = $clog2(LINE_WIDTH / 8);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e                             state_q, state_d;
  logic [CNT_W-1:0]                   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]              addr_q, addr_d;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]   wdata_q, wdata_d;
  logic [BEATS-1:0][BEAT_WIDTH-1:0]   rdata_q, rdata_d;

  // State, beat counter and latched line copies.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Next-state and memory-port outputs; mem_resp only advances the burst in READ/WRITE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    pmem_resp   = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        addr_d  = {pmem_address[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
        wdata_d = pmem_wdata;
        cnt_d   = '0;
        if (pmem_read) begin
          state_d = READ;
        end else if (pmem_write) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        mem_read    = 1'b1;
        mem_address = addr_q;
        if (mem_resp) begin
          rdata_d[cnt_q] = mem_rdata;
          cnt_d          = cnt_q + CNT_ONE;
          state_d        = (cnt_q == LAST_BEAT) ? DONE : READ;
        end else begin
          state_d = READ;
        end
      end
      WRITE: begin
        mem_write   = 1'b1;
        mem_address = addr_q;
        mem_wdata   = wdata_q[cnt_q];
        if (mem_resp) begin
          cnt_d   = cnt_q + CNT_ONE;
          state_d = (cnt_q == LAST_BEAT) ? DONE : WRITE;
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        pmem_resp = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pmem_rdata = rdata_q;

endmodule

// File: tb/tb_cacheline_adapter.sv
// Randomized self-checking bench for cacheline_adapter; a line-level model predicts
// burst address, write beats, read line, response latency and reset behaviour.
module tb_cacheline_adapter;

  logic         clk = 1'b0;
  logic         rst;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         mem_read, mem_write;
  logic [31:0]  mem_address;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int checks = 0;
  int errors = 0;

  // Model: the line the last completed (or reset) read left behind.
  logic [255:0] model_line;

  // Observations from the last transaction.
  int           r_resp_cyc, r_rd_cyc, r_wr_cyc, r_addr_err, r_wd_unstable, r_gaps, r_quiet_err;
  logic [31:0]  r_addr_seen;
  logic [255:0] r_wseen;
  bit           r_timeout;

  cacheline_adapter dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_address(mem_address), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Acts as arbiter and memory for one transaction, recording what the DUT did.
  task automatic do_txn(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [255:0] wline, input logic [255:0] rline,
                        input int gap_lo, input int gap_hi, input bit perturb);
    int beat = 0;
    int gap_left;
    int c = 1;
    bit have_addr = 1'b0;
    bit wd_have = 1'b0;
    bit done = 1'b0;
    logic [63:0] wd_first = 64'd0;
    r_resp_cyc = 0; r_rd_cyc = 0; r_wr_cyc = 0; r_addr_err = 0; r_wd_unstable = 0;
    r_gaps = 0; r_quiet_err = 0; r_addr_seen = 32'd0; r_wseen = 256'd0; r_timeout = 1'b0;
    pmem_read = rd; pmem_write = wr; pmem_address = addr; pmem_wdata = wline;
    mem_resp = perturb; mem_rdata = {$urandom(), $urandom()};
    step();
    mem_resp = 1'b0;
    gap_left = $urandom_range(gap_hi, gap_lo);
    while (!done && c <= 200) begin
      if (mem_read === 1'b1) r_rd_cyc++;
      if (mem_write === 1'b1) r_wr_cyc++;
      if (mem_read === 1'b1 || mem_write === 1'b1) begin
        if (!have_addr) begin
          r_addr_seen = mem_address;
          have_addr = 1'b1;
        end else if (mem_address !== r_addr_seen) begin
          r_addr_err++;
        end
      end
      if (pmem_resp === 1'b1) begin
        r_resp_cyc = c;
        done = 1'b1;
        pmem_read = 1'b0; pmem_write = 1'b0;
        mem_resp = perturb; mem_rdata = {$urandom(), $urandom()};
      end else begin
        if (perturb) begin
          pmem_address = $urandom();
          pmem_wdata = rand_line();
        end
        mem_resp = 1'b0;
        if ((mem_read === 1'b1 || mem_write === 1'b1) && beat < 4) begin
          if (mem_write === 1'b1) begin
            if (!wd_have) begin
              wd_first = mem_wdata;
              wd_have = 1'b1;
            end else if (mem_wdata !== wd_first) begin
              r_wd_unstable++;
            end
          end
          if (gap_left > 0) begin
            gap_left--;
            r_gaps++;
            mem_rdata = {$urandom(), $urandom()};
          end else begin
            mem_resp = 1'b1;
            mem_rdata = rline[64*beat +: 64];
            if (mem_write === 1'b1) r_wseen[64*beat +: 64] = mem_wdata;
            beat++;
            wd_have = 1'b0;
            gap_left = $urandom_range(gap_hi, gap_lo);
          end
        end
        step();
        c++;
      end
    end
    if (!done) begin
      r_timeout = 1'b1;
      pmem_read = 1'b0; pmem_write = 1'b0; mem_resp = 1'b0;
    end else begin
      step();
      if (pmem_resp !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) r_quiet_err++;
      mem_resp = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; pmem_read = 1'b1; pmem_write = 1'b0; mem_resp = 1'b1;
    pmem_address = 32'hDEAD_BEEF; pmem_wdata = rand_line(); mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if ({pmem_resp, mem_read, mem_write} !== 3'b000 || mem_address !== 32'd0 ||
          mem_wdata !== 64'd0 || pmem_rdata !== 256'd0) begin
        errors++;
        $display("FAIL reset_outputs: got resp=%b rd=%b wr=%b addr=%h wd=%h rdata=%h expected all zero",
                 pmem_resp, mem_read, mem_write, mem_address, mem_wdata, pmem_rdata);
      end
    end
    rst = 1'b0; pmem_read = 1'b0; mem_resp = 1'b0;
    step();
    checks++;
    if ({pmem_resp, mem_read, mem_write} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got resp=%b rd=%b wr=%b expected 000", pmem_resp, mem_read, mem_write);
    end
    model_line = 256'd0;
  endtask

  task automatic test_read_b2b();
    logic [255:0] line;
    line = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_txn(1'b1, 1'b0, 32'h0000_1234, rand_line(), line, 0, 0, 1'b0);
    checks++;
    if (r_timeout || r_resp_cyc !== 5) begin
      errors++;
      $display("FAIL rd_latency: got %0d (timeout=%0b) expected 5", r_resp_cyc, r_timeout);
    end
    checks++;
    if (r_addr_seen !== 32'h0000_1220 || r_addr_err !== 0) begin
      errors++;
      $display("FAIL rd_addr: got %h (%0d changes) expected 00001220", r_addr_seen, r_addr_err);
    end
    checks++;
    if (r_rd_cyc !== 4 || r_wr_cyc !== 0 || r_quiet_err !== 0) begin
      errors++;
      $display("FAIL rd_strobes: got rd=%0d wr=%0d quiet_err=%0d expected 4 0 0", r_rd_cyc, r_wr_cyc, r_quiet_err);
    end
    checks++;
    if (pmem_rdata !== line) begin
      errors++;
      $display("FAIL rd_line: got %h expected %h", pmem_rdata, line);
    end
    model_line = line;
    step();
    checks++;
    if (pmem_rdata !== model_line) begin
      errors++;
      $display("FAIL rd_line_hold: got %h expected %h", pmem_rdata, model_line);
    end
  endtask

  task automatic test_write_stall();
    logic [255:0] wl;
    logic [31:0] a;
    wl = rand_line();
    a = $urandom();
    do_txn(1'b0, 1'b1, a, wl, rand_line(), 2, 2, 1'b0);
    checks++;
    if (r_wseen !== wl || r_wd_unstable !== 0) begin
      errors++;
      $display("FAIL wr_beats: got %h (unstable=%0d) expected %h", r_wseen, r_wd_unstable, wl);
    end
    checks++;
    if (r_timeout || r_gaps !== 8 || r_resp_cyc !== 13) begin
      errors++;
      $display("FAIL wr_latency: got resp=%0d gaps=%0d expected 13 8", r_resp_cyc, r_gaps);
    end
    checks++;
    if (r_wr_cyc !== 12 || r_rd_cyc !== 0 || r_quiet_err !== 0) begin
      errors++;
      $display("FAIL wr_strobes: got wr=%0d rd=%0d quiet_err=%0d expected 12 0 0", r_wr_cyc, r_rd_cyc, r_quiet_err);
    end
    checks++;
    if (r_addr_seen !== (a & 32'hFFFF_FFE0) || r_addr_err !== 0) begin
      errors++;
      $display("FAIL wr_addr: got %h (%0d changes) expected %h", r_addr_seen, r_addr_err, a & 32'hFFFF_FFE0);
    end
    checks++;
    if (pmem_rdata !== model_line) begin
      errors++;
      $display("FAIL wr_keeps_rdata: got %h expected %h", pmem_rdata, model_line);
    end
  endtask

  task automatic test_both();
    logic [255:0] rl;
    rl = rand_line();
    do_txn(1'b1, 1'b1, $urandom(), rand_line(), rl, 0, 1, 1'b0);
    checks++;
    if (r_timeout || r_wr_cyc !== 0 || r_rd_cyc !== r_gaps + 4) begin
      errors++;
      $display("FAIL both_read_wins: got rd=%0d wr=%0d expected %0d 0", r_rd_cyc, r_wr_cyc, r_gaps + 4);
    end
    checks++;
    if (pmem_rdata !== rl) begin
      errors++;
      $display("FAIL both_line: got %h expected %h", pmem_rdata, rl);
    end
    model_line = rl;
  endtask

  task automatic test_perturb();
    logic [255:0] rl, wl;
    logic [31:0] a;
    pmem_read = 1'b0; pmem_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_resp = 1'b1; mem_rdata = {$urandom(), $urandom()}; pmem_address = $urandom();
      step();
    end
    mem_resp = 1'b0;
    rl = rand_line(); a = $urandom();
    do_txn(1'b1, 1'b0, a, rand_line(), rl, 0, 2, 1'b1);
    checks++;
    if (r_timeout || r_resp_cyc !== r_gaps + 5 || pmem_rdata !== rl) begin
      errors++;
      $display("FAIL pert_read: got resp=%0d line=%h expected %0d %h", r_resp_cyc, pmem_rdata, r_gaps + 5, rl);
    end
    checks++;
    if (r_addr_seen !== (a & 32'hFFFF_FFE0) || r_addr_err !== 0 || r_quiet_err !== 0) begin
      errors++;
      $display("FAIL pert_rd_addr: got %h (%0d changes, quiet_err=%0d) expected %h",
               r_addr_seen, r_addr_err, r_quiet_err, a & 32'hFFFF_FFE0);
    end
    model_line = rl;
    wl = rand_line(); a = $urandom();
    do_txn(1'b0, 1'b1, a, wl, rand_line(), 0, 2, 1'b1);
    checks++;
    if (r_timeout || r_wseen !== wl || r_wd_unstable !== 0 || r_resp_cyc !== r_gaps + 5) begin
      errors++;
      $display("FAIL pert_write: got %h resp=%0d expected %h %0d", r_wseen, r_resp_cyc, wl, r_gaps + 5);
    end
    checks++;
    if (r_addr_seen !== (a & 32'hFFFF_FFE0) || r_addr_err !== 0 || pmem_rdata !== model_line) begin
      errors++;
      $display("FAIL pert_wr_addr: got %h (%0d changes) expected %h", r_addr_seen, r_addr_err, a & 32'hFFFF_FFE0);
    end
  endtask

  task automatic test_reset_mid();
    logic [255:0] rl;
    int bad = 0;
    pmem_read = 1'b1; pmem_write = 1'b0; pmem_address = $urandom();
    step();
    for (int i = 0; i < 2; i++) begin
      mem_resp = 1'b1; mem_rdata = {$urandom(), $urandom()};
      step();
    end
    rst = 1'b1; pmem_read = 1'b0;
    step();
    checks++;
    if (mem_read !== 1'b0 || pmem_resp !== 1'b0 || pmem_rdata !== 256'd0) begin
      errors++;
      $display("FAIL rst_mid: got rd=%b resp=%b rdata=%h expected 0 0 0", mem_read, pmem_resp, pmem_rdata);
    end
    model_line = 256'd0;
    rst = 1'b0; mem_resp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pmem_resp !== 1'b0 || mem_read !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL rst_mid_quiet: got %0d active cycles expected 0", bad);
    end
    rl = rand_line();
    do_txn(1'b1, 1'b0, $urandom(), rand_line(), rl, 0, 0, 1'b0);
    checks++;
    if (r_timeout || r_resp_cyc !== 5 || pmem_rdata !== rl) begin
      errors++;
      $display("FAIL rst_mid_reread: got resp=%0d line=%h expected 5 %h", r_resp_cyc, pmem_rdata, rl);
    end
    model_line = rl;
  endtask

  task automatic test_random();
    for (int n = 0; n < 20; n++) begin
      int op;
      bit pert;
      logic [255:0] rl, wl;
      logic [31:0] a;
      logic [255:0] exp_w;
      op = $urandom_range(2, 0);
      pert = $urandom_range(1, 0);
      rl = rand_line(); wl = rand_line(); a = $urandom();
      do_txn(op != 1, op == 1 || op == 2, a, wl, rl, 0, 3, pert);
      if (op != 1) model_line = rl;
      exp_w = (op == 1) ? wl : 256'd0;
      checks++;
      if (r_timeout || r_resp_cyc !== r_gaps + 5 || r_quiet_err !== 0) begin
        errors++;
        $display("FAIL rnd_latency[%0d]: got %0d expected %0d", n, r_resp_cyc, r_gaps + 5);
      end
      checks++;
      if (r_addr_seen !== (a & 32'hFFFF_FFE0) || r_addr_err !== 0) begin
        errors++;
        $display("FAIL rnd_addr[%0d]: got %h expected %h", n, r_addr_seen, a & 32'hFFFF_FFE0);
      end
      checks++;
      if (r_rd_cyc !== ((op != 1) ? r_gaps + 4 : 0) || r_wr_cyc !== ((op == 1) ? r_gaps + 4 : 0)) begin
        errors++;
        $display("FAIL rnd_strobes[%0d]: got rd=%0d wr=%0d op=%0d gaps=%0d", n, r_rd_cyc, r_wr_cyc, op, r_gaps);
      end
      checks++;
      if (pmem_rdata !== model_line || r_wseen !== exp_w || r_wd_unstable !== 0) begin
        errors++;
        $display("FAIL rnd_data[%0d]: got line=%h wbeats=%h expected %h %h", n, pmem_rdata, r_wseen, model_line, exp_w);
      end
      for (int i = 0; i < int'($urandom_range(2, 0)); i++) step();
    end
  endtask

  initial begin
    rst = 1'b1; pmem_read = 1'b0; pmem_write = 1'b0; pmem_address = 32'd0;
    pmem_wdata = 256'd0; mem_rdata = 64'd0; mem_resp = 1'b0; model_line = 256'd0;
    test_reset();
    test_read_b2b();
    test_write_stall();
    test_both();
    test_perturb();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
